// File: rtl/reception_control_pkg.sv
// Shared codes, limits and state encoding for the UART receive-side write controller.
package reception_control_pkg;

    localparam int unsigned c_FILE_SIZE_BYTES = 26;
    localparam int unsigned c_TIMEOUT_CYCLES  = 10000;

    localparam logic [7:0] c_CMD_READ_REG   = 8'hAB;
    localparam logic [7:0] c_CMD_READ_BLOCK = 8'hAC;
    localparam logic [7:0] c_CMD_READ_ALL   = 8'hEE;
    localparam logic [7:0] c_CMD_WRITE_REG  = 8'hAD;

    localparam logic [7:0] c_ACK_BYTE = 8'h06;
    localparam logic [7:0] c_NAK_BYTE = 8'h15;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2,
        StCsum = 2'd3
    } rx_state_e;

    function automatic logic addr_in_range(input logic [7:0] addr);
        return 32'(addr) < c_FILE_SIZE_BYTES;
    endfunction

endpackage

// File: rtl/reception_control_if.sv
// Byte stream in from the UART receiver, register-file write and ACK/NAK request out.
interface reception_control_if;

    logic [7:0] w_rx_byte;
    logic       w_rx_dv;
    logic       o_wr_en;
    logic [7:0] o_wr_addr;
    logic [7:0] o_wr_data;
    logic       o_ack_dv;
    logic [7:0] o_ack_byte;
    logic       o_busy;
    logic       o_err_timeout;

    modport master (
        output w_rx_byte, w_rx_dv,
        input  o_wr_en, o_wr_addr, o_wr_data, o_ack_dv, o_ack_byte, o_busy, o_err_timeout
    );

    modport slave (
        input  w_rx_byte, w_rx_dv,
        output o_wr_en, o_wr_addr, o_wr_data, o_ack_dv, o_ack_byte, o_busy, o_err_timeout
    );

endinterface

// File: rtl/rx_timeout_timer.sv
// Inter-byte idle timer: expire_o flags the edge on which the count would reach Limit.
module rx_timeout_timer #(
    parameter int unsigned Limit = 10000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(Limit + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Clear has priority, so a byte arriving on the limit edge cancels the expiry.
    always_comb begin
        cnt_d    = cnt_q;
        expire_o = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            if (cnt_q == CntW'(Limit - 1)) begin
                expire_o = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reception_control.sv
// Parses CMD/ADDR/DATA[/CSUM] write frames and issues one register write plus ACK/NAK.
// RX_CHECKSUM_EN adds the trailing XOR checksum byte and its check.
module reception_control
    import reception_control_pkg::*;
#(
    parameter int unsigned TimeoutCycles = c_TIMEOUT_CYCLES
) (
    input  logic               i_clk_10,
    input  logic               i_rst,
    reception_control_if.slave rx_bus
);

    rx_state_e  state_q;
    logic [7:0] addr_q;
`ifdef RX_CHECKSUM_EN
    logic [7:0] data_q;
    logic [7:0] csum_q;
`endif
    logic       wr_en_q, ack_dv_q, err_q;
    logic [7:0] wr_addr_q, wr_data_q, ack_byte_q;

    logic       tmo_expire;
    logic       frame_last;
    logic       frame_ok;
    logic [7:0] frame_data;

    rx_timeout_timer #(
        .Limit(TimeoutCycles)
    ) u_timer (
        .clk_i   (i_clk_10),
        .rst_i   (i_rst),
        .clear_i (rx_bus.w_rx_dv || (state_q == StIdle)),
        .enable_i(state_q != StIdle),
        .expire_o(tmo_expire)
    );

    always_comb begin
`ifdef RX_CHECKSUM_EN
        frame_last = (state_q == StCsum);
        frame_data = data_q;
        frame_ok   = addr_in_range(addr_q) && (rx_bus.w_rx_byte == csum_q);
`else
        frame_last = (state_q == StData);
        frame_data = rx_bus.w_rx_byte;
        frame_ok   = addr_in_range(addr_q);
`endif
    end

    always_ff @(posedge i_clk_10 or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
`ifdef RX_CHECKSUM_EN
            data_q     <= '0;
            csum_q     <= '0;
`endif
            wr_en_q    <= 1'b0;
            ack_dv_q   <= 1'b0;
            err_q      <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            ack_byte_q <= '0;
        end else begin
            wr_en_q  <= 1'b0;
            ack_dv_q <= 1'b0;
            err_q    <= 1'b0;
            if (rx_bus.w_rx_dv && frame_last) begin
                state_q    <= StIdle;
                wr_addr_q  <= addr_q;
                wr_data_q  <= frame_data;
                wr_en_q    <= frame_ok;
                ack_dv_q   <= 1'b1;
                ack_byte_q <= frame_ok ? c_ACK_BYTE : c_NAK_BYTE;
            end else if (rx_bus.w_rx_dv) begin
                // Inside a frame every byte is payload, including 0xAD.
                case (state_q)
                    StIdle: begin
                        if (rx_bus.w_rx_byte == c_CMD_WRITE_REG) state_q <= StAddr;
                    end
                    StAddr: begin
                        addr_q  <= rx_bus.w_rx_byte;
                        state_q <= StData;
                    end
`ifdef RX_CHECKSUM_EN
                    StData: begin
                        data_q  <= rx_bus.w_rx_byte;
                        csum_q  <= c_CMD_WRITE_REG ^ addr_q ^ rx_bus.w_rx_byte;
                        state_q <= StCsum;
                    end
`endif
                    default: state_q <= StIdle;
                endcase
            end else if (tmo_expire) begin
                state_q    <= StIdle;
                err_q      <= 1'b1;
                ack_dv_q   <= 1'b1;
                ack_byte_q <= c_NAK_BYTE;
            end
        end
    end

    assign rx_bus.o_wr_en       = wr_en_q;
    assign rx_bus.o_wr_addr     = wr_addr_q;
    assign rx_bus.o_wr_data     = wr_data_q;
    assign rx_bus.o_ack_dv      = ack_dv_q;
    assign rx_bus.o_ack_byte    = ack_byte_q;
    assign rx_bus.o_err_timeout = err_q;
    assign rx_bus.o_busy        = (state_q != StIdle);

endmodule

// File: tb/tb_reception_control.sv
// Bench for reception_control: frame table plus timeout/reset/ignore sequences, scoreboard-checked.
module tb_reception_control;
    import reception_control_pkg::*;

    localparam int unsigned T = c_TIMEOUT_CYCLES;
`ifdef RX_CHECKSUM_EN
    localparam bit CsumEn = 1'b1;
`else
    localparam bit CsumEn = 1'b0;
`endif

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] ack;
        logic       tmo;
        int         due;
    } exp_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        bit         bad;
        int         gap;
        logic       exp_wr;
        logic [7:0] exp_ack;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[8];

    reception_control_if bus ();

    reception_control dut (
        .i_clk_10(clk),
        .i_rst   (rst),
        .rx_bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input logic wr, input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] ack, input logic tmo, input int due);
        exp_t e;
        e.wr = wr; e.addr = a; e.data = d; e.ack = ack; e.tmo = tmo; e.due = due;
        sb.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        bus.w_rx_byte = b;
        bus.w_rx_dv   = 1'b1;
        @(posedge clk);
        #1;
        bus.w_rx_dv   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input bit bad,
                              input int gap, input logic exp_wr, input logic [7:0] exp_ack);
        logic [7:0] cs;
        cs = c_CMD_WRITE_REG ^ a ^ d;
        send(c_CMD_WRITE_REG);
        idle(gap);
        send(a);
        idle(gap);
        if (CsumEn) begin
            send(d);
            idle(gap);
            push_exp(exp_wr, a, d, exp_ack, 1'b0, cyc + 1);
            send(bad ? 8'h00 : cs);
        end else begin
            push_exp(exp_wr, a, d, exp_ack, 1'b0, cyc + 1);
            send(d);
        end
    endtask

    // Scoreboard: every ack_dv must match the oldest expectation on its exact cycle.
    always @(negedge clk) begin
        if (bus.o_ack_dv) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack 0x%0h wr_en %0b, required no response (cycle %0d)",
                         bus.o_ack_byte, bus.o_wr_en, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("ack_cycle", cyc, mon_e.due);
                check("ack_byte", {24'd0, bus.o_ack_byte}, {24'd0, mon_e.ack});
                check("wr_en", {31'd0, bus.o_wr_en}, {31'd0, mon_e.wr});
                check("err_timeout", {31'd0, bus.o_err_timeout}, {31'd0, mon_e.tmo});
                if (mon_e.wr) begin
                    check("wr_addr", {24'd0, bus.o_wr_addr}, {24'd0, mon_e.addr});
                    check("wr_data", {24'd0, bus.o_wr_data}, {24'd0, mon_e.data});
                end
            end
        end else begin
            check("stray_strobe", {30'd0, bus.o_wr_en, bus.o_err_timeout}, 32'd0);
        end
        if (sb.size() > 0 && cyc > sb[0].due) begin
            n_chk++;
            n_fail++;
            $display("FAIL missing_response: got nothing, required ack 0x%0h by cycle %0d",
                     sb[0].ack, sb[0].due);
            void'(sb.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.w_rx_dv   = 1'b0;
        bus.w_rx_byte = 8'h00;
        rst           = 1'b1;

        vecs[0] = '{8'h05, 8'h3C, 1'b0, 0, 1'b1, c_ACK_BYTE};
        vecs[1] = '{8'h05, 8'h3C, 1'b1, 0, !CsumEn, CsumEn ? c_NAK_BYTE : c_ACK_BYTE};
        vecs[2] = '{8'h1A, 8'h11, 1'b0, 0, 1'b0, c_NAK_BYTE};
        vecs[3] = '{8'h19, 8'hFF, 1'b0, 0, 1'b1, c_ACK_BYTE};
        vecs[4] = '{8'h00, 8'hAD, 1'b0, 0, 1'b1, c_ACK_BYTE};
        vecs[5] = '{8'hAD, 8'h01, 1'b0, 0, 1'b0, c_NAK_BYTE};
        vecs[6] = '{8'hFF, 8'h00, 1'b1, 0, 1'b0, c_NAK_BYTE};
        vecs[7] = '{8'h0C, 8'h5A, 1'b0, 3, 1'b1, c_ACK_BYTE};

        @(posedge clk);
        #1;
        idle(2);
        check("rst_wr_en", {31'd0, bus.o_wr_en}, 32'd0);
        check("rst_ack_dv", {31'd0, bus.o_ack_dv}, 32'd0);
        check("rst_ack_byte", {24'd0, bus.o_ack_byte}, 32'd0);
        check("rst_wr_addr", {24'd0, bus.o_wr_addr}, 32'd0);
        check("rst_wr_data", {24'd0, bus.o_wr_data}, 32'd0);
        check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
        check("rst_err", {31'd0, bus.o_err_timeout}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Table frames go out back-to-back with no gap cycles between them.
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].addr, vecs[i].data, vecs[i].bad, vecs[i].gap,
                       vecs[i].exp_wr, vecs[i].exp_ack);
        end
        idle(3);

        // Read-type commands and stray bytes are ignored in idle.
        send(c_CMD_READ_REG);
        send(8'h41);
        send(c_CMD_READ_BLOCK);
        send(c_CMD_READ_ALL);
        check("ignored_busy", {31'd0, bus.o_busy}, 32'd0);
        send_frame(8'h07, 8'hC3, 1'b0, 0, 1'b1, c_ACK_BYTE);
        send_frame(8'h01, 8'h11, 1'b0, 0, 1'b1, c_ACK_BYTE);
        send_frame(8'h02, 8'h22, 1'b0, 0, 1'b1, c_ACK_BYTE);
        idle(3);

        // Timeout after ADDR: silence for the full limit aborts the frame.
        send(c_CMD_WRITE_REG);
        send(8'h02);
        check("frame_busy", {31'd0, bus.o_busy}, 32'd1);
        push_exp(1'b0, 8'h00, 8'h00, c_NAK_BYTE, 1'b1, cyc + T);
        idle(T - 1);
        check("busy_before_timeout", {31'd0, bus.o_busy}, 32'd1);
        idle(1);
        check("busy_after_timeout", {31'd0, bus.o_busy}, 32'd0);
        idle(3);

        // One idle cycle short of the limit: the byte lands on the limit edge and wins.
        send(c_CMD_WRITE_REG);
        send(8'h03);
        idle(T - 1);
        if (CsumEn) begin
            send(8'h5A);
            push_exp(1'b1, 8'h03, 8'h5A, c_ACK_BYTE, 1'b0, cyc + 1);
            send(c_CMD_WRITE_REG ^ 8'h03 ^ 8'h5A);
        end else begin
            push_exp(1'b1, 8'h03, 8'h5A, c_ACK_BYTE, 1'b0, cyc + 1);
            send(8'h5A);
        end
        idle(3);

        // Reset mid-frame: outputs clear at once and the frame is dropped.
        send(c_CMD_WRITE_REG);
        send(8'h04);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_wr_addr", {24'd0, bus.o_wr_addr}, 32'd0);
        check("midrst_wr_data", {24'd0, bus.o_wr_data}, 32'd0);
        check("midrst_ack_byte", {24'd0, bus.o_ack_byte}, 32'd0);
        check("midrst_busy", {31'd0, bus.o_busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        send(8'h66);
        check("post_rst_idle", {31'd0, bus.o_busy}, 32'd0);
        send_frame(8'h04, 8'h55, 1'b0, 0, 1'b1, c_ACK_BYTE);
        idle(5);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
